vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA sync/timing generator with a pixel-path pipeline. It replaces
//   the fixed 640x480 counter/comparator top with one block that supports any
//   resolution, sync polarity and pixel-source latency.
//  Drives the HS/VS pins and the blanked RGB444 pixel bus, and gives the image
//   generator the x/y coordinates of the pixel it must supply.
// PARAMETERS
//  H_VISIBLE 640  active pixels per line
//  H_FRONT   16   horizontal front porch, in pixels
//  H_SYNC    96   horizontal sync width, in pixels
//  H_BACK    48   horizontal back porch, in pixels
//  V_VISIBLE 480  active lines per frame
//  V_FRONT   10   vertical front porch, in lines
//  V_SYNC    2    vertical sync width, in lines
//  V_BACK    33   vertical back porch, in lines
//  HS_POL    0    HS level during sync (0 = active-low)
//  VS_POL    0    VS level during sync (0 = active-low)
//  PIPE_DEPTH 1   pixel-source latency in cycles (>=1); sync/de are delayed to match
//  CNT_W     10   width of the counter and coordinate ports; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
//  clk_25MHz  in  1       pixel clock
//  rst        in  1       synchronous, active-high reset
//  en         in  1       pixel-clock enable; tie high at 25 MHz
//  test_mode  in  1       selects the colour-bar pattern (only with VGA_TEST_PATTERN_EN)
//  pixel_in   in  12      RGB444 from the image generator, for the pix_x/pix_y requested PIPE_DEPTH-1 cycles earlier
//  h_count    out CNT_W   raw horizontal counter
//  v_count    out CNT_W   raw vertical counter
//  pix_x      out CNT_W   h_count-(H_SYNC+H_BACK) when visible, else 0
//  pix_y      out CNT_W   v_count-(V_SYNC+V_BACK) when visible, else 0
//  pix_req    out 1       counters are inside the visible window (stage 0)
//  HS         out 1       horizontal sync, delayed by PIPE_DEPTH
//  VS         out 1       vertical sync, delayed by PIPE_DEPTH
//  de         out 1       data enable, aligned with pixel_out
//  frame_start out 1      1-cycle pulse at h=0,v=0, delayed by PIPE_DEPTH
//  line_start  out 1      1-cycle pulse at h=0, delayed by PIPE_DEPTH
//  pixel_out  out 12      blanked RGB444 to the DAC
// BEHAVIOUR
//  - H_TOTAL = H_SYNC+H_BACK+H_VISIBLE+H_FRONT; V_TOTAL is defined the same way.
//    Line order is sync, back porch, visible, front porch.
//  - Counters advance only on edges where en=1. h wraps from H_TOTAL-1 to 0 and
//    increments v in the same edge. When v=V_TOTAL-1 and h wraps, both go to 0.
//  - While en=0, all registers hold (counters, delay line, pixel_out).
//  - Stage-0 decode from counters, all combinational:
//    - hs0 = (h < H_SYNC); vs0 = (v < V_SYNC).
//    - vis0 = h in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VISIBLE) AND v in the vertical equivalent.
//    - Visible window at defaults: h 144..783, v 35..514.
//  - pix_req = vis0, and pix_x/pix_y are combinational from the counters (0 cycles).
//  - Delay line: PIPE_DEPTH registers for hs/vs/vis/fs/ls. HS = hs_d[PIPE_DEPTH] ? HS_POL : ~HS_POL; VS uses VS_POL the same way.
//  - pixel_out <= vis_d[PIPE_DEPTH-1] ? pixel_in : 12'h000 (registered); de = vis_d[PIPE_DEPTH].
//  - Total latency from counter state to pins is PIPE_DEPTH cycles.
//  - Reset (sync, overrides en):
//    - counters 0; delay line cleared; pixel_out 0; de, frame_start, line_start 0.
//    - HS = ~HS_POL, VS = ~VS_POL.
//    - Reset mid-frame restarts at h=0,v=0. The first frame_start appears PIPE_DEPTH enabled cycles after rst falls.
//  - Outside the visible window, pixel_out must be 0 regardless of pixel_in.
//  - Elaboration error if PIPE_DEPTH<1 or H_TOTAL/V_TOTAL does not fit in CNT_W.
// CONFIGURATION
//  - VGA_TEST_PATTERN_EN defined: when test_mode=1, the pixel_out mux selects 8
//    vertical colour bars instead of pixel_in. Bar index = pix_x*8/H_VISIBLE from
//    the aligned (delayed) x. Colours in order: FFF,FF0,0FF,0F0,F0F,F00,00F,000.
//    Blanking still applies.
//  - VGA_TEST_PATTERN_EN undefined: test_mode is ignored and the bar logic is not synthesised.
// TESTING
//  1. rst=1 for 3 cycles, en=1, defaults -> h_count=v_count=0, HS=VS=1, de=0, pixel_out=000.
//  2. Free run one line -> HS low for exactly 96 of 800 cycles; de high for 640
//     contiguous cycles starting at h_count=145 (PIPE_DEPTH=1); line_start every 800 cycles.
//  3. Free run 2 frames -> VS low for 1600 cycles; frame_start period 420000 cycles;
//     v wraps 524->0.
//  4. pixel_in={pix_x[3:0],pix_y[3:0],4'hA}, PIPE_DEPTH=3 with a matching model
//     source -> pixel_out equals the model value whenever de=1, else 000.
//  5. en toggled 1010.. for 1 line, plus en=0 held for 50 cycles mid-line -> all
//     outputs frozen while en=0; the line takes 800 enabled cycles. rst pulse at
//     v=300 -> restart per the reset rules.
//  6. With VGA_TEST_PATTERN_EN, test_mode=1 -> pixel_out=FFF at x=0..79, 000 at x=560..639.
//     Without the macro -> pixel_out follows pixel_in.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/timing generator with a PIPE_DEPTH-matched pixel pipeline.
// Define VGA_TEST_PATTERN_EN to build in the 8-bar colour test pattern (selected by test_mode).
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0,
  parameter int PIPE_DEPTH = 1,
  parameter int CNT_W      = 10
) (
  input  logic             clk_25MHz,
  input  logic             rst,
  input  logic             en,
  input  logic             test_mode,
  input  logic [11:0]      pixel_in,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             pix_req,
  output logic             HS,
  output logic             VS,
  output logic             de,
  output logic             frame_start,
  output logic             line_start,
  output logic [11:0]      pixel_out
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;

  if (PIPE_DEPTH < 1) begin : g_bad_depth
    $error("vga_timing_gen: PIPE_DEPTH must be at least 1");
  end
  if ((H_TOTAL > (1 << CNT_W)) || (V_TOTAL > (1 << CNT_W))) begin : g_bad_width
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT0     = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_ACT1     = CNT_W'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [CNT_W-1:0] V_ACT0     = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_ACT1     = CNT_W'(V_SYNC + V_BACK + V_VISIBLE);
  localparam logic             HS_LVL     = 1'(HS_POL);
  localparam logic             VS_LVL     = 1'(VS_POL);

  typedef struct packed {
    logic hs;
    logic vs;
    logic vis;
    logic fs;
    logic ls;
  } ctl_t;

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;

  always_comb begin
    h_d = h_q + CNT_W'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else if (en) begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Stage 0: combinational decode of the raw counters
  ctl_t ctl_p0;

  always_comb begin
    ctl_p0.hs  = (h_q < H_SYNC_END);
    ctl_p0.vs  = (v_q < V_SYNC_END);
    ctl_p0.vis = (h_q >= H_ACT0) && (h_q < H_ACT1) && (v_q >= V_ACT0) && (v_q < V_ACT1);
    ctl_p0.fs  = (h_q == '0) && (v_q == '0);
    ctl_p0.ls  = (h_q == '0);
  end

  assign h_count = h_q;
  assign v_count = v_q;
  assign pix_req = ctl_p0.vis;
  assign pix_x   = ctl_p0.vis ? (h_q - H_ACT0) : '0;
  assign pix_y   = ctl_p0.vis ? (v_q - V_ACT0) : '0;

  // Stages 1..PIPE_DEPTH: control delay line; ctl_s[k] is stage k
  ctl_t [PIPE_DEPTH:0]   ctl_s;
  ctl_t [PIPE_DEPTH-1:0] ctl_q;

  assign ctl_s = {ctl_q, ctl_p0};

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      ctl_q <= '0;
    end else if (en) begin
      ctl_q <= ctl_s[PIPE_DEPTH-1:0];
    end
  end

  assign HS          = ctl_s[PIPE_DEPTH].hs ? HS_LVL : ~HS_LVL;
  assign VS          = ctl_s[PIPE_DEPTH].vs ? VS_LVL : ~VS_LVL;
  assign de          = ctl_s[PIPE_DEPTH].vis;
  assign frame_start = ctl_s[PIPE_DEPTH].fs;
  assign line_start  = ctl_s[PIPE_DEPTH].ls;

  logic [11:0] pix_src;

`ifdef VGA_TEST_PATTERN_EN
  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 12'hFFF;
      3'd1:    bar_colour = 12'hFF0;
      3'd2:    bar_colour = 12'h0FF;
      3'd3:    bar_colour = 12'h0F0;
      3'd4:    bar_colour = 12'hF0F;
      3'd5:    bar_colour = 12'hF00;
      3'd6:    bar_colour = 12'h00F;
      default: bar_colour = 12'h000;
    endcase
  endfunction

  localparam logic [CNT_W+2:0] HVIS_W = (CNT_W+3)'(H_VISIBLE);

  // x must line up with stage PIPE_DEPTH-1, where the pixel register loads
  logic [CNT_W-1:0] x_al;
  logic [CNT_W+2:0] x8;
  logic [2:0]       bar_idx;

  if (PIPE_DEPTH == 1) begin : g_x_direct
    assign x_al = pix_x;
  end else begin : g_x_dly
    logic [CNT_W-1:0] x_q [PIPE_DEPTH-1];
    always_ff @(posedge clk_25MHz) begin
      if (en) begin
        x_q[0] <= pix_x;
        for (int k = 1; k < PIPE_DEPTH - 1; k++) x_q[k] <= x_q[k-1];
      end
    end
    assign x_al = x_q[PIPE_DEPTH-2];
  end

  assign x8      = {x_al, 3'b000};
  assign bar_idx = 3'(x8 / HVIS_W);
  assign pix_src = test_mode ? bar_colour(bar_idx) : pixel_in;
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign pix_src          = pixel_in;
`endif

  // Stage PIPE_DEPTH: blanked pixel register, aligned with de
  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      pixel_out <= 12'h000;
    end else if (en) begin
      pixel_out <= ctl_s[PIPE_DEPTH-1].vis ? pix_src : 12'h000;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance (PIPE_DEPTH=1) and a tiny
// timing instance (PIPE_DEPTH=3, HS active-high) checked against a position-based model.
module tb_vga_timing_gen;

  localparam int PD_B = 3;

`ifdef VGA_TEST_PATTERN_EN
  localparam bit TP = 1'b1;
`else
  localparam bit TP = 1'b0;
`endif

  typedef struct {
    int hv, hf, hsw, hb, vv, vf, vsw, vb, hpol, vpol, pd;
  } cfg_t;

  typedef struct {
    int h, v, x, y;
    bit vis, hs, vs, fs, ls;
  } pos_t;

  typedef struct {
    int n, h, v, x, y, req, hs, vs, de, ls, fs, pix;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, en_a, tm_a;
  logic [11:0] pin_a;
  logic [9:0]  ha, va, xa, ya;
  logic        req_a, hs_a, vs_a, de_a, fs_a, ls_a;
  logic [11:0] pout_a;

  logic        rst_b, en_b, tm_b;
  logic [11:0] pin_b;
  logic [4:0]  hb, vb, xb, yb;
  logic        req_b, hs_b, vs_b, de_b, fs_b, ls_b;
  logic [11:0] pout_b;

  vga_timing_gen u_a (
    .clk_25MHz(clk), .rst(rst_a), .en(en_a), .test_mode(tm_a), .pixel_in(pin_a),
    .h_count(ha), .v_count(va), .pix_x(xa), .pix_y(ya), .pix_req(req_a),
    .HS(hs_a), .VS(vs_a), .de(de_a), .frame_start(fs_a), .line_start(ls_a),
    .pixel_out(pout_a)
  );

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .HS_POL(1), .VS_POL(0), .PIPE_DEPTH(PD_B), .CNT_W(5)
  ) u_b (
    .clk_25MHz(clk), .rst(rst_b), .en(en_b), .test_mode(tm_b), .pixel_in(pin_b),
    .h_count(hb), .v_count(vb), .pix_x(xb), .pix_y(yb), .pix_req(req_b),
    .HS(hs_b), .VS(vs_b), .de(de_b), .frame_start(fs_b), .line_start(ls_b),
    .pixel_out(pout_b)
  );

  cfg_t        cfg   [2];
  longint      mn    [2];
  logic [11:0] mpix  [2];
  bit          armed [2];
  int          checks = 0;
  int          errors = 0;
  bit          b_rand = 1'b0;

  // Position n (enabled cycles since reset) -> what the spec says the raw timing is there
  function automatic pos_t decode(cfg_t c, longint n);
    pos_t   p;
    int     ht = c.hsw + c.hb + c.hv + c.hf;
    int     vt = c.vsw + c.vb + c.vv + c.vf;
    int     ah = c.hsw + c.hb;
    int     av = c.vsw + c.vb;
    longint m  = n % longint'(ht * vt);
    p.h   = int'(m % ht);
    p.v   = int'(m / ht);
    p.hs  = p.h < c.hsw;
    p.vs  = p.v < c.vsw;
    p.vis = (p.h >= ah) && (p.h < ah + c.hv) && (p.v >= av) && (p.v < av + c.vv);
    p.x   = p.vis ? p.h - ah : 0;
    p.y   = p.vis ? p.v - av : 0;
    p.fs  = (p.h == 0) && (p.v == 0);
    p.ls  = (p.h == 0);
    return p;
  endfunction

  function automatic logic [11:0] bar(int x, int hv);
    logic [11:0] pal [8];
    pal = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    return pal[(x * 8) / hv];
  endfunction

  task automatic cmp(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(int i, logic r, logic e, logic tm, logic [11:0] pin);
    longint q;
    pos_t   p;
    if (r) begin
      mn[i]    = 0;
      mpix[i]  = 12'h000;
      armed[i] = 1'b1;
    end else if (e) begin
      q       = mn[i] - (cfg[i].pd - 1);
      mpix[i] = 12'h000;
      if (q >= 0) begin
        p = decode(cfg[i], q);
        if (p.vis) mpix[i] = (TP && tm) ? bar(p.x, cfg[i].hv) : pin;
      end
      mn[i]++;
    end
  endtask

  task automatic check_model(int i, string nm, int h, int v, int x, int y, int req,
                             int hs, int vs, int de, int fs, int ls, int pix);
    pos_t c, p;
    int   ehs, evs, ede, efs, els;
    if (!armed[i]) return;
    c   = decode(cfg[i], mn[i]);
    ehs = (cfg[i].hpol == 0) ? 1 : 0;
    evs = (cfg[i].vpol == 0) ? 1 : 0;
    ede = 0; efs = 0; els = 0;
    if (mn[i] >= cfg[i].pd) begin
      p   = decode(cfg[i], mn[i] - cfg[i].pd);
      ehs = p.hs ? cfg[i].hpol : 1 - cfg[i].hpol;
      evs = p.vs ? cfg[i].vpol : 1 - cfg[i].vpol;
      ede = int'(p.vis);
      efs = int'(p.fs);
      els = int'(p.ls);
    end
    cmp({nm, ".h_count"}, h, c.h);
    cmp({nm, ".v_count"}, v, c.v);
    cmp({nm, ".pix_x"}, x, c.x);
    cmp({nm, ".pix_y"}, y, c.y);
    cmp({nm, ".pix_req"}, req, int'(c.vis));
    cmp({nm, ".HS"}, hs, ehs);
    cmp({nm, ".VS"}, vs, evs);
    cmp({nm, ".de"}, de, ede);
    cmp({nm, ".frame_start"}, fs, efs);
    cmp({nm, ".line_start"}, ls, els);
    cmp({nm, ".pixel_out"}, pix, int'(mpix[i]));
  endtask

  task automatic tick();
    longint q;
    pos_t   p;
    if (b_rand) begin
      rst_b = ($urandom_range(0, 399) == 0);
      en_b  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) tm_b = ~tm_b;
      pin_b = 12'($urandom);
      q = mn[1] - (PD_B - 1);
      if (q >= 0) begin
        p = decode(cfg[1], q);
        if (p.vis) pin_b = {4'(p.x), 4'(p.y), 4'hA};
      end
    end
    @(posedge clk);
    model_step(0, rst_a, en_a, tm_a, pin_a);
    model_step(1, rst_b, en_b, tm_b, pin_b);
    #1;
    check_model(0, "A", int'(ha), int'(va), int'(xa), int'(ya), int'(req_a), int'(hs_a),
                int'(vs_a), int'(de_a), int'(fs_a), int'(ls_a), int'(pout_a));
    check_model(1, "B", int'(hb), int'(vb), int'(xb), int'(yb), int'(req_b), int'(hs_b),
                int'(vs_b), int'(de_b), int'(fs_b), int'(ls_b), int'(pout_b));
  endtask

  task automatic run_to_h(int tgt);
    int k = 0;
    while ((mn[0] % 800) != tgt && k < 3000) begin
      tick();
      k++;
    end
    cmp($sformatf("reach_h%0d", tgt), int'(mn[0] % 800), tgt);
  endtask

  initial begin
    vec_t tbl [12];
    bit   ens [5];
    int   fse [5];

    tbl[0]  = '{0,       0,  0,   0, 0, 0, 1, 1, 0, 0, 0, 'h000};
    tbl[1]  = '{1,       1,  0,   0, 0, 0, 0, 0, 0, 1, 1, 'h000};
    tbl[2]  = '{96,     96,  0,   0, 0, 0, 0, 0, 0, 0, 0, 'h000};
    tbl[3]  = '{97,     97,  0,   0, 0, 0, 1, 0, 0, 0, 0, 'h000};
    tbl[4]  = '{800,     0,  1,   0, 0, 0, 1, 0, 0, 0, 0, 'h000};
    tbl[5]  = '{801,     1,  1,   0, 0, 0, 0, 0, 0, 1, 0, 'h000};
    tbl[6]  = '{1601,    1,  2,   0, 0, 0, 0, 1, 0, 1, 0, 'h000};
    tbl[7]  = '{28144, 144, 35,   0, 0, 1, 1, 1, 0, 0, 0, 'h000};
    tbl[8]  = '{28145, 145, 35,   1, 0, 1, 1, 1, 1, 0, 0, 'h5C3};
    tbl[9]  = '{28783, 783, 35, 639, 0, 1, 1, 1, 1, 0, 0, 'h5C3};
    tbl[10] = '{28784, 784, 35,   0, 0, 0, 1, 1, 1, 0, 0, 'h5C3};
    tbl[11] = '{28785, 785, 35,   0, 0, 0, 1, 1, 0, 0, 0, 'h000};

    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 1};
    cfg[1] = '{16, 3, 4, 5, 6, 2, 2, 3, 1, 0, PD_B};
    mn     = '{0, 0};
    mpix   = '{12'h000, 12'h000};
    armed  = '{1'b0, 1'b0};

    rst_a = 1'b1; en_a = 1'b1; tm_a = 1'b0; pin_a = 12'h5C3;
    rst_b = 1'b1; en_b = 1'b1; tm_b = 1'b0; pin_b = 12'h000;
    repeat (3) tick();
    rst_a  = 1'b0;
    b_rand = 1'b1;

    for (int i = 0; i < 12; i++) begin
      while (mn[0] < tbl[i].n) tick();
      cmp($sformatf("T%0d.h", i), int'(ha), tbl[i].h);
      cmp($sformatf("T%0d.v", i), int'(va), tbl[i].v);
      cmp($sformatf("T%0d.x", i), int'(xa), tbl[i].x);
      cmp($sformatf("T%0d.y", i), int'(ya), tbl[i].y);
      cmp($sformatf("T%0d.req", i), int'(req_a), tbl[i].req);
      cmp($sformatf("T%0d.HS", i), int'(hs_a), tbl[i].hs);
      cmp($sformatf("T%0d.VS", i), int'(vs_a), tbl[i].vs);
      cmp($sformatf("T%0d.de", i), int'(de_a), tbl[i].de);
      cmp($sformatf("T%0d.ls", i), int'(ls_a), tbl[i].ls);
      cmp($sformatf("T%0d.fs", i), int'(fs_a), tbl[i].fs);
      cmp($sformatf("T%0d.pix", i), int'(pout_a), tbl[i].pix);
    end

    // en held low mid-line: everything frozen
    while (mn[0] < 29200) tick();
    pin_a = 12'h777;
    en_a  = 1'b0;
    repeat (50) begin
      tick();
      cmp("hold.h", int'(ha), 400);
      cmp("hold.v", int'(va), 36);
      cmp("hold.de", int'(de_a), 1);
      cmp("hold.pix", int'(pout_a), 'h5C3);
    end

    // en toggling: one line costs 800 enabled cycles
    for (int k = 0; k < 1600; k++) begin
      en_a = (k % 2 == 0);
      tick();
    end
    cmp("toggle.h", int'(ha), 400);
    cmp("toggle.v", int'(va), 37);

    for (int k = 0; k < 3000; k++) begin
      en_a  = ($urandom_range(0, 3) != 0);
      pin_a = 12'($urandom);
      if (k % 50 == 0) tm_a = 1'($urandom_range(0, 1));
      tick();
    end

    // colour bars (or pass-through) on a visible line
    en_a = 1'b1; tm_a = 1'b1; pin_a = 12'h3C5;
    run_to_h(145);
    cmp("bar.x0", int'(pout_a), TP ? 'hFFF : 'h3C5);
    run_to_h(225);
    cmp("bar.x80", int'(pout_a), TP ? 'hFF0 : 'h3C5);
    run_to_h(705);
    cmp("bar.x560", int'(pout_a), TP ? 'h000 : 'h3C5);
    tm_a = 1'b0;

    // mid-frame reset overrides en
    rst_a = 1'b1; en_a = 1'b0;
    tick();
    cmp("rst.h", int'(ha), 0);
    cmp("rst.v", int'(va), 0);
    cmp("rst.HS", int'(hs_a), 1);
    cmp("rst.VS", int'(vs_a), 1);
    cmp("rst.de", int'(de_a), 0);
    cmp("rst.fs", int'(fs_a), 0);
    cmp("rst.pix", int'(pout_a), 0);
    rst_a = 1'b0;
    tick();
    cmp("rst.fs_held", int'(fs_a), 0);
    en_a = 1'b1;
    tick();
    cmp("rst.fs_first", int'(fs_a), 1);
    cmp("rst.ls_first", int'(ls_a), 1);
    cmp("rst.HS_sync", int'(hs_a), 0);

    // deep pipe: first frame_start after PIPE_DEPTH enabled cycles
    b_rand = 1'b0;
    rst_b = 1'b1; en_b = 1'b0;
    tick();
    cmp("B.rst.HS", int'(hs_b), 0);
    cmp("B.rst.VS", int'(vs_b), 1);
    rst_b = 1'b0;
    ens = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    fse = '{0, 0, 0, 0, 1};
    for (int k = 0; k < 5; k++) begin
      en_b = ens[k];
      tick();
      cmp($sformatf("B.fs%0d", k), int'(fs_b), fse[k]);
    end
    cmp("B.HS_sync", int'(hs_b), 1);
    cmp("B.VS_sync", int'(vs_b), 0);
    tick();
    cmp("B.fs_pulse_end", int'(fs_b), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
